// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word packer.
// Holds the packer state enum, the byte width, the default pad value and
// the lane-position helper used by the lane write decode.
package uart_pkg;

  localparam int         BYTE_W       = 8;
  localparam logic [7:0] DEF_PAD_BYTE = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } pack_state_t;

  // Bit offset of byte lane 'fill' inside a word of 'word_bytes' bytes.
  // MSB-first puts the first byte in the top lane.
  function automatic int lane_base(input int fill, input int word_bytes, input bit msb_first);
    return msb_first ? (word_bytes - 1 - fill) * BYTE_W : fill * BYTE_W;
  endfunction

endpackage

// File: rtl/pack_idle_timer.sv
// Idle timer for the word packer: counts cycles while i_run is high and
// i_clr is low, and raises o_expire for one cycle when the count reaches
// TIMEOUT_CYC-1. Only instantiated when PACK_TIMEOUT_EN is defined.
module pack_idle_timer #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_clr,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] r_cnt;

  // Terminal count reached while running and not being restarted.
  assign o_expire = i_run && !i_clr && (r_cnt == CW'(TIMEOUT_CYC - 1));

  // Idle cycle counter; restarts on any accepted byte or when not running.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr || !i_run) begin
      r_cnt <= '0;
    end else if (!o_expire) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_word_packer.sv
// uart_word_packer: packs a byte stream into WORD_BYTES*8-bit words.
// Optional feature macro: PACK_TIMEOUT_EN (idle-timeout partial flush).
//
// Handshakes (both sides): a transfer happens on a rising edge where
// valid and ready are both high; the sender holds data stable while valid
// is high and not yet taken; ready is registered on the byte side.
// o_state exposes the FSM state for debug (0 IDLE, 1 COLLECT, 2 HOLD).
module uart_word_packer
  import uart_pkg::*;
#(
  parameter int         WORD_BYTES  = 32,
  parameter int         MSB_FIRST   = 1,
  parameter logic [7:0] PAD_BYTE    = DEF_PAD_BYTE,
  parameter int         TIMEOUT_CYC = 1024,
  parameter int         CNT_W       = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [7:0]                        i_byte,
  input  logic                              i_byte_valid,
  output logic                              o_byte_ready,
  input  logic                              i_trig,
  output logic [WORD_BYTES*8-1:0]           o_word,
  output logic                              o_word_valid,
  input  logic                              i_word_ready,
  output logic [$clog2(WORD_BYTES+1)-1:0]   o_word_bytes,
  output logic                              o_partial,
  output logic [$clog2(WORD_BYTES+1)-1:0]   o_fill,
  output logic [CNT_W-1:0]                  o_word_cnt,
  output logic [1:0]                        o_state
);

  localparam int W  = WORD_BYTES * BYTE_W;
  localparam int FW = $clog2(WORD_BYTES + 1);
  localparam int LW = $clog2(W);

  pack_state_t    r_state, w_state_nxt;
  logic [W-1:0]   r_word;
  logic [FW-1:0]  r_fill;
  logic [FW-1:0]  r_word_bytes;
  logic           r_word_valid;
  logic           r_partial;
  logic           r_byte_ready;
  logic [CNT_W-1:0] r_word_cnt;

  logic           w_accept;
  logic [FW-1:0]  w_fill_next;
  logic           w_full;
  logic           w_flush;
  logic           w_timeout;
  logic           w_take;
  logic [LW-1:0]  w_lane_base;

  assign w_accept    = i_byte_valid && r_byte_ready;
  assign w_fill_next = r_fill + FW'(w_accept);
  assign w_full      = (w_fill_next == FW'(WORD_BYTES));
  // Flush counts the byte accepted this cycle, so trig with one new byte still flushes.
  assign w_flush     = (i_trig || w_timeout) && (w_fill_next != '0);
  assign w_take      = r_word_valid && i_word_ready;
  assign w_lane_base = LW'(lane_base(int'(r_fill), WORD_BYTES, MSB_FIRST != 0));

`ifdef PACK_TIMEOUT_EN
  pack_idle_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_idle_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_run   ((r_state == ST_COLLECT) && (r_fill != '0)),
    .i_clr   (w_accept),
    .o_expire(w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: arm, close a word (full or flushed), release on handoff.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (i_trig) w_state_nxt = ST_COLLECT;
      ST_COLLECT: if (w_full || w_flush) w_state_nxt = ST_HOLD;
      ST_HOLD:    if (w_take) w_state_nxt = ST_COLLECT;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: lane buffer, fill, word status, delivered-word counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_word       <= {WORD_BYTES{PAD_BYTE}};
      r_fill       <= '0;
      r_word_valid <= 1'b0;
      r_word_bytes <= '0;
      r_partial    <= 1'b0;
      r_word_cnt   <= '0;
      r_byte_ready <= 1'b0;
    end else begin
      r_byte_ready <= (w_state_nxt == ST_COLLECT);
      case (r_state)
        ST_IDLE: begin
          if (i_trig) begin
            r_word <= {WORD_BYTES{PAD_BYTE}};
            r_fill <= '0;
          end
        end
        ST_COLLECT: begin
          if (w_accept) begin
            r_word[w_lane_base +: BYTE_W] <= i_byte;
          end
          r_fill <= w_fill_next;
          if (w_full || w_flush) begin
            r_word_valid <= 1'b1;
            r_word_bytes <= w_fill_next;
            r_partial    <= !w_full;
          end
        end
        ST_HOLD: begin
          if (w_take) begin
            r_word_valid <= 1'b0;
            r_word_cnt   <= r_word_cnt + CNT_W'(1);
            r_fill       <= '0;
            r_word       <= {WORD_BYTES{PAD_BYTE}};
          end
        end
        default: ;
      endcase
    end
  end

  assign o_byte_ready = r_byte_ready;
  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;
  assign o_word_bytes = r_word_bytes;
  assign o_partial    = r_partial;
  assign o_fill       = r_fill;
  assign o_word_cnt   = r_word_cnt;
  assign o_state      = r_state;

endmodule

// File: tb/tb_uart_word_packer.sv
// Testbench for uart_word_packer: directed steps with random byte data,
// checked against a byte-queue model of the packing rules.
module tb_uart_word_packer;
  import uart_pkg::*;

  localparam int         WB   = 32;
  localparam int         W    = WB * 8;
  localparam int         FW   = $clog2(WB + 1);
  localparam logic [7:0] PAD  = 8'hEE;
  localparam int         TO   = 16;
  localparam int         CW   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]    i_byte = '0;
  logic          i_byte_valid = 1'b0;
  logic          o_byte_ready;
  logic          i_trig = 1'b0;
  logic [W-1:0]  o_word;
  logic          o_word_valid;
  logic          i_word_ready = 1'b0;
  logic [FW-1:0] o_word_bytes;
  logic          o_partial;
  logic [FW-1:0] o_fill;
  logic [CW-1:0] o_word_cnt;
  logic [1:0]    o_state;

  uart_word_packer #(
    .WORD_BYTES(WB), .MSB_FIRST(1), .PAD_BYTE(PAD), .TIMEOUT_CYC(TO), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
    .o_byte_ready(o_byte_ready), .i_trig(i_trig), .o_word(o_word),
    .o_word_valid(o_word_valid), .i_word_ready(i_word_ready),
    .o_word_bytes(o_word_bytes), .o_partial(o_partial), .o_fill(o_fill),
    .o_word_cnt(o_word_cnt), .o_state(o_state)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]   cur_q[$];
  logic [W-1:0] exp_q[$];
  int           exp_bytes_q[$];
  bit           exp_part_q[$];
  int           exp_cnt = 0;
  bit           armed = 0;
  logic [W-1:0] pad_word;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Build a word by shifting in bytes in arrival order, padded to WB bytes.
  function automatic logic [W-1:0] model_word();
    logic [W-1:0] w = '0;
    for (int k = 0; k < WB; k++) begin
      logic [7:0] b = (k < cur_q.size()) ? cur_q[k] : PAD;
      w = {w[W-9:0], b};
    end
    return w;
  endfunction

  task automatic close_word(input bit partial);
    exp_q.push_back(model_word());
    exp_bytes_q.push_back(cur_q.size());
    exp_part_q.push_back(partial);
    cur_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_trig();
    if (!armed) armed = 1;
    else if (exp_q.size() == 0 && cur_q.size() > 0) close_word(1);
  endtask

  task automatic pulse_trig();
    i_trig = 1'b1;
    tick();
    i_trig = 1'b0;
    model_trig();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit trig);
    int guard = 0;
    while (o_byte_ready !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) begin
      chk("byte_ready_timeout", {{(W-1){1'b0}}, o_byte_ready}, 1);
      return;
    end
    i_byte = b;
    i_byte_valid = 1'b1;
    i_trig = trig;
    tick();
    i_byte_valid = 1'b0;
    i_trig = 1'b0;
    cur_q.push_back(b);
    if (cur_q.size() == WB) close_word(0);
    else if (trig) close_word(1);
  endtask

  task automatic take_word(input string tag);
    int guard = 0;
    logic [W-1:0] ew;
    int eb;
    bit ep;
    while (o_word_valid !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50 || exp_q.size() == 0) begin
      chk({tag, "_valid_timeout"}, {{(W-1){1'b0}}, o_word_valid}, exp_q.size() != 0);
      return;
    end
    ew = exp_q.pop_front();
    eb = exp_bytes_q.pop_front();
    ep = exp_part_q.pop_front();
    chk({tag, "_word"}, o_word, ew);
    chk({tag, "_bytes"}, o_word_bytes, eb);
    chk({tag, "_partial"}, o_partial, ep);
    i_word_ready = 1'b1;
    tick();
    i_word_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    chk({tag, "_cnt"}, o_word_cnt, exp_cnt);
    chk({tag, "_valid_drop"}, o_word_valid, 0);
    chk({tag, "_fill_clr"}, o_fill, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, o_byte_ready, 0);
    chk({tag, "_valid"}, o_word_valid, 0);
    chk({tag, "_word"}, o_word, pad_word);
    chk({tag, "_bytes"}, o_word_bytes, 0);
    chk({tag, "_partial"}, o_partial, 0);
    chk({tag, "_fill"}, o_fill, 0);
    chk({tag, "_cnt"}, o_word_cnt, 0);
    chk({tag, "_state"}, o_state, ST_IDLE);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    pad_word = {WB{PAD}};

    // Reset state
    tick(); tick();
    check_reset_outputs("rst");
    i_rst = 1'b0;
    tick();
    chk("idle_no_ready", o_byte_ready, 0);
    pulse_trig();
    chk("arm_ready", o_byte_ready, 1);
    chk("arm_state", o_state, ST_COLLECT);

    // 1: full word 0x00..0x1F, MSB first
    for (int i = 0; i < WB; i++) send_byte(8'(i), 0);
    chk("t1_latency_valid", o_word_valid, 1);
    chk("t1_fill_full", o_fill, WB);
    chk("t1_top_lane", o_word[W-1 -: 8], 8'h00);
    chk("t1_low_lane", o_word[7:0], 8'h1F);
    take_word("t1");

    // 2: back-pressure for 10 cycles; trig in hold is ignored
    for (int i = 0; i < WB; i++) send_byte(8'($urandom_range(0, 255)), 0);
    for (int i = 0; i < 10; i++) begin
      i_trig = (i == 4);
      tick();
      i_trig = 1'b0;
      chk("t2_hold_ready", o_byte_ready, 0);
      chk("t2_hold_valid", o_word_valid, 1);
      chk("t2_hold_word", o_word, exp_q[0]);
    end
    take_word("t2");
    chk("t2_ready_after", o_byte_ready, 1);

    // 3: five bytes then trig -> partial
    send_byte(8'hA1, 0);
    chk("t2_next_accepted", o_fill, 1);
    for (int i = 2; i <= 5; i++) send_byte(8'(8'hA0 + i), 0);
    pulse_trig();
    chk("t3_pad_lanes", o_word[W-41:0], pad_word[W-41:0]);
    take_word("t3");
    pulse_trig();
    tick();
    chk("t3_trig_empty_ignored", o_word_valid, 0);
    chk("t3_trig_empty_state", o_state, ST_COLLECT);

    // 4: 31st byte + trig -> partial of 31; 32nd byte + trig -> full
    for (int i = 0; i < WB - 1; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send_byte(8'($urandom_range(0, 255)), i == WB - 2);
    end
    take_word("t4_p31");
    for (int i = 0; i < WB; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send_byte(8'($urandom_range(0, 255)), i == WB - 1);
    end
    take_word("t4_full");
    send_byte(8'($urandom_range(0, 255)), 1);
    take_word("t4_p1");

    // 5: idle after 3 bytes
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 0);
`ifdef PACK_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (k == TO - 1) chk("t5_no_early_flush", o_word_valid, 0);
      if (k == TO) chk("t5_timeout_flush", o_word_valid, 1);
    end
    close_word(1);
    take_word("t5_to");
`else
    repeat (3 * TO) tick();
    chk("t5_no_flush", o_word_valid, 0);
    chk("t5_fill_kept", o_fill, 3);
    pulse_trig();
    take_word("t5_trig");
`endif

    // Counter wrap with single-byte partial words
    for (int i = 0; i < 14; i++) begin
      send_byte(8'($urandom_range(0, 255)), 1);
      take_word("wrap");
    end

    // 6: reset mid-word
    for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)), 0);
    i_rst = 1'b1;
    tick();
    check_reset_outputs("t6");
    i_rst = 1'b0;
    cur_q.delete(); exp_q.delete(); exp_bytes_q.delete(); exp_part_q.delete();
    exp_cnt = 0; armed = 0;
    tick();
    pulse_trig();
    send_byte(8'h5C, 1);
    take_word("t6_recover");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
